genram_mc: RTL and testbench

//  Parametrised multi-channel pixel RAM: next generation of the J1 SoC framebuffer store.
//  - One synchronous port; CHANNELS independent lanes of CH_W bits (default: R, G, B bytes).
//  - Valid/ready command handshake with per-lane write mask.
//  - Auto-increment address pointer for streaming pixel access.
//  - Hardware clear engine that fills every location with CLEAR_VAL.
//  - Sits between the J1 bus bridge and the video scan-out logic.

---
 rtl/genram_mc.sv | 107 ++++++++++
 tb/tb_genram_mc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/genram_mc.sv
// Multi-channel pixel RAM with lane write mask, auto-increment pointer and clear engine.
// Single synchronous port: one access per cycle, read data registered one cycle after accept.
module genram_mc #(
    parameter int              CHANNELS  = 3,
    parameter int              CH_W      = 8,
    parameter int              DEPTH     = 102400,
    parameter int              AW        = 17,
    parameter logic [CH_W-1:0] CLEAR_VAL = '0,
    parameter                  ROMFILE   = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic                     cmd_inc,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [CHANNELS*CH_W-1:0] wdata,
    input  logic [CHANNELS-1:0]      wmask,
    output logic [CHANNELS*CH_W-1:0] rdata,
    output logic                     rvalid,
    output logic [AW-1:0]            ptr,
    input  logic                     clr_start,
    output logic                     busy,
    output logic                     addr_err
);
    localparam int            DW   = CHANNELS * CH_W;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_nx;
    logic [AW-1:0]        clr_a;
    logic [AW-1:0]        ea;
    logic                 in_range;
    logic                 accept;
    logic [CHANNELS-1:0]  lane_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem [DEPTH];

    assign ea       = cmd_inc ? ptr : cmd_addr;
    // LAST avoids needing DEPTH to fit in AW bits when DEPTH == 2**AW
    assign in_range = (ea <= LAST);
    assign accept   = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clr_start)      state_nx = CLEAR;
            CLEAR:   if (clr_a == LAST)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        lane_we   = '0;
        mem_addr  = ea;
        mem_wdata = wdata;
        case (state)
            IDLE: begin
                cmd_ready = ~clr_start;
                if (cmd_valid && !clr_start && cmd_wr && in_range) lane_we = wmask;
            end
            CLEAR: begin
                busy      = 1'b1;
                lane_we   = '1;
                mem_addr  = clr_a;
                mem_wdata = {CHANNELS{CLEAR_VAL}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (lane_we[k]) mem[mem_addr][k*CH_W +: CH_W] <= mem_wdata[k*CH_W +: CH_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_a    <= '0;
            ptr      <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
        end else begin
            clr_a    <= (state == CLEAR) ? clr_a + AW'(1) : '0;
            rvalid   <= accept & ~cmd_wr;
            addr_err <= accept & ~in_range;
            if (accept) begin
                if (!in_range)       ptr <= '0;
                else if (ea == LAST) ptr <= '0;
                else                 ptr <= ea + AW'(1);
                if (!cmd_wr) rdata <= in_range ? mem[ea] : '0;
            end
        end
    end
endmodule

// File: tb/tb_genram_mc.sv
// Directed bench for genram_mc with a small DEPTH so the clear engine finishes quickly.
module tb_genram_mc;
    localparam int          CHANNELS = 3;
    localparam int          CH_W     = 8;
    localparam int          DEPTH    = 100;
    localparam int          AW       = 7;
    localparam logic [7:0]  CV       = 8'h10;
    localparam logic [23:0] CLR_WORD = 24'h101010;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_wr;
    logic                     cmd_inc;
    logic [AW-1:0]            cmd_addr;
    logic [CHANNELS*CH_W-1:0] wdata;
    logic [CHANNELS-1:0]      wmask;
    logic [CHANNELS*CH_W-1:0] rdata;
    logic                     rvalid;
    logic [AW-1:0]            ptr;
    logic                     clr_start;
    logic                     busy;
    logic                     addr_err;

    int checks = 0;
    int errors = 0;

    genram_mc #(.CHANNELS(CHANNELS), .CH_W(CH_W), .DEPTH(DEPTH), .AW(AW),
                .CLEAR_VAL(CV), .ROMFILE("")) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_inc(cmd_inc), .cmd_addr(cmd_addr), .wdata(wdata),
        .wmask(wmask), .rdata(rdata), .rvalid(rvalid), .ptr(ptr),
        .clr_start(clr_start), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Present one command for a single cycle; returns at the negedge after the accepting posedge.
    task automatic issue(input logic wr, input logic inc, input logic [AW-1:0] addr,
                         input logic [23:0] data, input logic [2:0] mask);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_inc = inc; cmd_addr = addr;
        wdata = data; wmask = mask;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_inc = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_inc = 1'b0; cmd_addr = '0;
        wdata = '0; wmask = '0; clr_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ptr !== 7'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", ptr); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
    endtask

    task automatic test_mask;
        issue(1'b1, 1'b0, 7'd5, 24'hAABBCC, 3'b111);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b want 0", rvalid); end
        issue(1'b1, 1'b0, 7'd5, 24'h112233, 3'b010);
        issue(1'b0, 1'b0, 7'd5, 24'h0, 3'b000);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mask_rvalid got %b want 1", rvalid); end
        checks++; if (rdata !== 24'hAA22CC) begin errors++; $display("FAIL mask_rdata got %h want AA22CC", rdata); end
        checks++; if (ptr !== 7'd6) begin errors++; $display("FAIL mask_ptr got %0d want 6", ptr); end
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b want 0", rvalid); end
        checks++; if (rdata !== 24'hAA22CC) begin errors++; $display("FAIL rdata_hold got %h want AA22CC", rdata); end
    endtask

    task automatic test_wrap;
        issue(1'b1, 1'b0, 7'(DEPTH - 2), 24'h010203, 3'b111);
        issue(1'b1, 1'b1, 7'd0, 24'h040506, 3'b111);
        checks++; if (ptr !== 7'd0) begin errors++; $display("FAIL wrap_ptr0 got %0d want 0", ptr); end
        issue(1'b1, 1'b1, 7'd0, 24'h070809, 3'b111);
        checks++; if (ptr !== 7'd1) begin errors++; $display("FAIL wrap_ptr1 got %0d want 1", ptr); end
        issue(1'b0, 1'b0, 7'(DEPTH - 1), 24'h0, 3'b000);
        checks++; if (rdata !== 24'h040506) begin errors++; $display("FAIL wrap_last got %h want 040506", rdata); end
        issue(1'b0, 1'b0, 7'd0, 24'h0, 3'b000);
        checks++; if (rdata !== 24'h070809) begin errors++; $display("FAIL wrap_zero got %h want 070809", rdata); end
    endtask

    task automatic test_oob;
        issue(1'b0, 1'b0, 7'd3, 24'h0, 3'b000);  // leaves ptr at 4 so the reset to 0 is visible
        issue(1'b0, 1'b0, 7'(DEPTH), 24'h0, 3'b000);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL oob_rvalid got %b want 1", rvalid); end
        checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL oob_rdata got %h want 0", rdata); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", addr_err); end
        checks++; if (ptr !== 7'd0) begin errors++; $display("FAIL oob_ptr got %0d want 0", ptr); end
        @(negedge clk);
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oob_err_pulse got %b want 0", addr_err); end
        // An in-range access right after must not be flagged
        issue(1'b1, 1'b0, 7'd20, 24'h332211, 3'b111);
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL inrange_err got %b want 0", addr_err); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_inc = 1'b0; cmd_addr = 7'd10; wdata = 24'h123456; wmask = 3'b111;
        @(negedge clk);
        cmd_wr = 1'b0; cmd_addr = 7'd10;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== 24'h123456) begin
            errors++; $display("FAIL b2b_rd1 got %b/%h want 1/123456", rvalid, rdata); end
        checks++; if (ptr !== 7'd11) begin errors++; $display("FAIL b2b_ptr got %0d want 11", ptr); end
        cmd_wr = 1'b1; cmd_inc = 1'b1; wdata = 24'h654321;
        @(negedge clk);
        checks++; if (rvalid !== 1'b0 || rdata !== 24'h123456) begin
            errors++; $display("FAIL b2b_wr2 got %b/%h want 0/123456", rvalid, rdata); end
        cmd_wr = 1'b0; cmd_inc = 1'b0; cmd_addr = 7'd11;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 24'h654321) begin
            errors++; $display("FAIL b2b_rd2 got %b/%h want 1/654321", rvalid, rdata); end
    endtask

    task automatic test_clear;
        int cnt;
        int ready_bad;
        issue(1'b1, 1'b0, 7'd3, 24'hABCDEF, 3'b111);
        @(negedge clk);
        clr_start = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'd7; wdata = 24'h777777; wmask = 3'b111;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_same got %b want 0", cmd_ready); end
        @(negedge clk);
        clr_start = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0;
        cnt = 0; ready_bad = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (cmd_ready !== 1'b0) ready_bad++;
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != DEPTH) begin errors++; $display("FAIL clr_cycles got %0d want %0d", cnt, DEPTH); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL clr_ready_busy got %0d want 0", ready_bad); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_after got %b want 1", cmd_ready); end
        issue(1'b0, 1'b0, 7'd7, 24'h0, 3'b000);
        checks++; if (rdata !== CLR_WORD) begin errors++; $display("FAIL clr_dropped got %h want 101010", rdata); end
        issue(1'b0, 1'b0, 7'd3, 24'h0, 3'b000);
        checks++; if (rdata !== CLR_WORD) begin errors++; $display("FAIL clr_addr3 got %h want 101010", rdata); end
        issue(1'b0, 1'b0, 7'(DEPTH - 1), 24'h0, 3'b000);
        checks++; if (rdata !== CLR_WORD) begin errors++; $display("FAIL clr_last got %h want 101010", rdata); end
    endtask

    task automatic test_reset_clear;
        issue(1'b1, 1'b0, 7'd90, 24'h5A5A5A, 3'b111);
        issue(1'b0, 1'b0, 7'd4, 24'h0, 3'b000);  // ptr=5, rdata nonzero before the abort
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rc_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rc_busy got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rc_ready got %b want 1", cmd_ready); end
        checks++; if (ptr !== 7'd0 || rdata !== 24'h0) begin
            errors++; $display("FAIL rc_regs got ptr=%0d rdata=%h want 0/0", ptr, rdata); end
        rst = 1'b0;
        issue(1'b0, 1'b0, 7'd90, 24'h0, 3'b000);
        checks++; if (rdata !== 24'h5A5A5A) begin errors++; $display("FAIL rc_kept got %h want 5A5A5A", rdata); end
        issue(1'b0, 1'b0, 7'd2, 24'h0, 3'b000);
        checks++; if (rdata !== CLR_WORD) begin errors++; $display("FAIL rc_cleared got %h want 101010", rdata); end
    endtask

    initial begin
        test_reset;
        test_mask;
        test_wrap;
        test_oob;
        test_back_to_back;
        test_clear;
        test_reset_clear;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
